// File: rtl/board_access_arbiter.sv
// Round-robin arbiter sharing the single-port board RAM between N requesters, with freeze/drain handshake.
// Optional bounds checking of (row, col) is enabled by defining BOARD_ARB_BOUNDS_CHECK_EN.

module board_addr_calc #(
    parameter int COLS = 28
) (
    input  logic [5:0] row,
    input  logic [4:0] col,
    output logic [9:0] addr
);
    // 10-bit arithmetic wraps naturally, giving the modulo-1024 address
    assign addr = 10'(row) * 10'(COLS) + 10'(col);
endmodule

module board_access_arbiter #(
    parameter int N_REQ = 3,
    parameter int COLS  = 28,
    parameter int ROWS  = 36
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [N_REQ-1:0]   i_req,
    input  logic [N_REQ-1:0]   i_we,
    input  logic [6*N_REQ-1:0] i_row,
    input  logic [5*N_REQ-1:0] i_col,
    input  logic [8*N_REQ-1:0] i_wdata,
    output logic [N_REQ-1:0]   o_gnt,
    output logic [N_REQ-1:0]   o_rvalid,
    output logic [7:0]         o_rdata,
    output logic               o_err,
    output logic [9:0]         o_ram_addr,
    output logic [7:0]         o_ram_data,
    output logic               o_ram_wren,
    input  logic [7:0]         i_ram_q,
    input  logic               i_freeze,
    output logic               o_frozen
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_FROZEN} state_t;

    state_t                  state;
    logic [IDX_W-1:0]        last_gnt;
    logic [IDX_W-1:0]        cand;
    logic [IDX_W-1:0]        win;
    logic [N_REQ-1:0]        gnt;
    logic                    allow;
    logic [N_REQ-1:0][9:0]   req_addr;
    logic [9:0]              sel_addr;
    logic [7:0]              sel_data;
    logic                    sel_we;
    logic                    sel_oob;
    // Requester one-hot ID per read stage: [0] = RAM sampling, [1] = data return
    logic [1:0][N_REQ-1:0]   rd_pipe;

    for (genvar k = 0; k < N_REQ; k++) begin : g_addr
        board_addr_calc #(.COLS(COLS)) u_addr (
            .row  (i_row[6*k +: 6]),
            .col  (i_col[5*k +: 5]),
            .addr (req_addr[k])
        );
    end

`ifdef BOARD_ARB_BOUNDS_CHECK_EN
    logic [N_REQ-1:0] req_oob;
    logic [1:0]       oob_pipe;
    for (genvar k = 0; k < N_REQ; k++) begin : g_oob
        assign req_oob[k] = (int'(i_row[6*k +: 6]) >= ROWS) || (int'(i_col[5*k +: 5]) >= COLS);
    end
    assign o_err = |(gnt & req_oob);
`else
    assign sel_oob = 1'b0;
    assign o_err   = 1'b0;
`endif

    // Reset gates grants combinationally so every output is 0 while reset is held
    assign allow = i_rst_n && (state == S_RUN) && !i_freeze;

    always_comb begin
        gnt  = '0;
        win  = last_gnt;
        cand = last_gnt;
        for (int i = 0; i < N_REQ; i++) begin
            cand = (cand == IDX_W'(N_REQ-1)) ? '0 : cand + IDX_W'(1);
            if (allow && gnt == '0 && i_req[cand]) begin
                gnt[cand] = 1'b1;
                win       = cand;
            end
        end
    end

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        sel_we   = 1'b0;
`ifdef BOARD_ARB_BOUNDS_CHECK_EN
        sel_oob  = 1'b0;
`endif
        for (int k = 0; k < N_REQ; k++) begin
            if (gnt[k]) begin
                sel_addr = req_addr[k];
                sel_data = i_wdata[8*k +: 8];
                sel_we   = i_we[k];
`ifdef BOARD_ARB_BOUNDS_CHECK_EN
                sel_oob  = req_oob[k];
`endif
            end
        end
    end

    assign o_gnt    = gnt;
    assign o_rvalid = rd_pipe[1];

`ifdef BOARD_ARB_BOUNDS_CHECK_EN
    assign o_rdata = (|o_rvalid) ? (oob_pipe[1] ? 8'hFF : i_ram_q) : 8'h00;
`else
    assign o_rdata = (|o_rvalid) ? i_ram_q : 8'h00;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_ram_addr <= '0;
            o_ram_data <= '0;
            o_ram_wren <= 1'b0;
            rd_pipe    <= '0;
            last_gnt   <= IDX_W'(N_REQ-1);
`ifdef BOARD_ARB_BOUNDS_CHECK_EN
            oob_pipe   <= '0;
`endif
        end else begin
            o_ram_wren <= 1'b0;
            if (|gnt) begin
                o_ram_addr <= sel_addr;
                o_ram_data <= sel_data;
                o_ram_wren <= sel_we & ~sel_oob;
                last_gnt   <= win;
            end
            rd_pipe <= {rd_pipe[0], (sel_we ? {N_REQ{1'b0}} : gnt)};
`ifdef BOARD_ARB_BOUNDS_CHECK_EN
            oob_pipe <= {oob_pipe[0], sel_oob};
`endif
        end
    end

    // Freeze FSM: drain in-flight accesses before handing the RAM to the reload sequencer
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= S_RUN;
            o_frozen <= 1'b0;
        end else begin
            case (state)
                S_RUN: begin
                    if (i_freeze) state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (!i_freeze) begin
                        state <= S_RUN;
                    end else if (!o_ram_wren && rd_pipe == '0) begin
                        state    <= S_FROZEN;
                        o_frozen <= 1'b1;
                    end
                end
                S_FROZEN: begin
                    if (!i_freeze) begin
                        state    <= S_RUN;
                        o_frozen <= 1'b0;
                    end
                end
                default: begin
                    state    <= S_RUN;
                    o_frozen <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_board_access_arbiter.sv
// Directed bench for board_access_arbiter: read returns are checked by a scoreboard monitor,
// grants, RAM port and freeze behaviour are checked inline.
module tb_board_access_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  req = '0, we = '0;
    logic [17:0] row = '0;
    logic [14:0] col = '0;
    logic [23:0] wdata = '0;
    logic [2:0]  gnt, rvalid;
    logic [7:0]  rdata, ram_data, ram_q;
    logic        err, ram_wren, freeze = 1'b0, frozen;
    logic [9:0]  ram_addr;

    logic [7:0]  mem [1024];
    logic [10:0] sb [$];
    logic [10:0] exp_rd;
    int          n_vec = 0;
    int          n_fail = 0;

    board_access_arbiter #(.N_REQ(3), .COLS(28), .ROWS(36)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_we(we), .i_row(row), .i_col(col),
        .i_wdata(wdata), .o_gnt(gnt), .o_rvalid(rvalid), .o_rdata(rdata), .o_err(err),
        .o_ram_addr(ram_addr), .o_ram_data(ram_data), .o_ram_wren(ram_wren),
        .i_ram_q(ram_q), .i_freeze(freeze), .o_frozen(frozen)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM, 1-cycle read latency
    always @(posedge clk) begin
        if (ram_wren) mem[ram_addr] <= ram_data;
        ram_q <= mem[ram_addr];
    end

    // Read-return monitor
    always @(negedge clk) begin
        if (rst_n && rvalid != 3'b000) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL rd_unexpected: got rvalid=%b rdata=%h, required no return", rvalid, rdata);
            end else begin
                exp_rd = sb.pop_front();
                if ({rvalid, rdata} !== exp_rd) begin
                    n_fail++;
                    $display("FAIL rd_return: got rvalid=%b rdata=%h, required rvalid=%b rdata=%h",
                             rvalid, rdata, exp_rd[10:8], exp_rd[7:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int k, input logic w, input int r, input int c, input logic [7:0] d);
        req[k] = 1'b1;
        we[k]  = w;
        row[6*k +: 6]   = 6'(r);
        col[5*k +: 5]   = 5'(c);
        wdata[8*k +: 8] = d;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({gnt, rvalid, rdata, err, ram_addr, ram_data, ram_wren, frozen});
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, required finish before timeout");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ 8'hA5;
        mem[59] = 8'h10;

        // Reset state
        @(negedge clk);
        check("reset_outputs", all_outs(), 32'h0);
        do_reset();

        // Single read by requester 1 at (2,3) -> address 59
        put(1, 1'b0, 2, 3, 8'h00);
        @(negedge clk);
        check("rd1_gnt", 32'(gnt), 32'h2);
        sb.push_back({3'b010, 8'h10});
        next();
        req = '0;
        @(negedge clk);
        check("rd1_addr", 32'(ram_addr), 32'd59);
        check("rd1_wren", 32'(ram_wren), 32'd0);
        repeat (3) next();

        // All three hold reads: grants 0,1,2,0,1,2 after reset
        do_reset();
        put(0, 1'b0, 0, 0, 8'h00);   // addr 0   -> A5
        put(1, 1'b0, 1, 1, 8'h00);   // addr 29  -> B8
        put(2, 1'b0, 10, 6, 8'h00);  // addr 286 -> BB
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rr_gnt", 32'(gnt), 32'(3'b001 << (i % 3)));
            case (i % 3)
                0: sb.push_back({3'b001, 8'hA5});
                1: sb.push_back({3'b010, 8'hB8});
                default: sb.push_back({3'b100, 8'hBB});
            endcase
            next();
        end
        req = '0;
        repeat (3) next();

        // Requester 0 writes 0 to (35,27) -> address 1007, one-cycle wren, no rvalid
        put(0, 1'b1, 35, 27, 8'h00);
        @(negedge clk);
        check("wr_gnt", 32'(gnt), 32'h1);
        next();
        req = '0;
        we  = '0;
        @(negedge clk);
        check("wr_addr", 32'(ram_addr), 32'd1007);
        check("wr_wren", 32'(ram_wren), 32'd1);
        check("wr_data", 32'(ram_data), 32'h0);
        next();
        @(negedge clk);
        check("wr_wren_off", 32'(ram_wren), 32'd0);
        next();

        // Freeze with reads in flight
        put(0, 1'b0, 35, 27, 8'h00);  // reads back the written 0
        @(negedge clk);
        check("fz_gnt_a", 32'(gnt), 32'h1);
        sb.push_back({3'b001, 8'h00});
        next();
        req = '0;
        put(1, 1'b0, 2, 3, 8'h00);
        @(negedge clk);
        check("fz_gnt_b", 32'(gnt), 32'h2);
        sb.push_back({3'b010, 8'h10});
        next();
        req = '0;
        put(0, 1'b0, 0, 0, 8'h00);
        put(2, 1'b0, 10, 6, 8'h00);
        freeze = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("fz_no_gnt", 32'(gnt), 32'h0);
            if (i >= 3) begin
                check("fz_frozen", 32'(frozen), 32'd1);
                check("fz_wren", 32'(ram_wren), 32'd0);
            end
            next();
        end
        freeze = 1'b0;
        @(negedge clk);
        check("unfz_hold", 32'(gnt), 32'h0);
        next();
        @(negedge clk);
        check("unfz_gnt2", 32'(gnt), 32'h4);
        check("unfz_frozen", 32'(frozen), 32'd0);
        sb.push_back({3'b100, 8'hBB});
        next();
        req[2] = 1'b0;
        @(negedge clk);
        check("unfz_gnt0", 32'(gnt), 32'h1);
        sb.push_back({3'b001, 8'hA5});
        next();
        req = '0;
        repeat (3) next();

        // Out-of-range read (36,0) and write (0,28)
        put(1, 1'b0, 36, 0, 8'h00);
        @(negedge clk);
        check("oob_gnt", 32'(gnt), 32'h2);
`ifdef BOARD_ARB_BOUNDS_CHECK_EN
        check("oob_err", 32'(err), 32'd1);
        sb.push_back({3'b010, 8'hFF});
`else
        check("oob_err", 32'(err), 32'd0);
        sb.push_back({3'b010, 8'h55});
`endif
        next();
        req = '0;
        @(negedge clk);
        check("oob_err_off", 32'(err), 32'd0);
        check("oob_rd_wren", 32'(ram_wren), 32'd0);
`ifndef BOARD_ARB_BOUNDS_CHECK_EN
        check("oob_addr", 32'(ram_addr), 32'd1008);
`endif
        next();
        put(0, 1'b1, 0, 28, 8'h77);
        @(negedge clk);
        check("oob_wr_gnt", 32'(gnt), 32'h1);
        next();
        req = '0;
        we  = '0;
        @(negedge clk);
`ifdef BOARD_ARB_BOUNDS_CHECK_EN
        check("oob_wr_wren", 32'(ram_wren), 32'd0);
`else
        check("oob_wr_wren", 32'(ram_wren), 32'd1);
        check("oob_wr_addr", 32'(ram_addr), 32'd28);
`endif
        repeat (3) next();

        // Reset in the middle of a read
        put(2, 1'b0, 0, 0, 8'h00);
        @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'h4);
        sb.push_back({3'b100, 8'hA5});
        next();
        rst_n = 1'b0;
        #1;
        check("rst_mid_outputs", all_outs(), 32'h0);
        sb.delete();
        req = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_no_rvalid", 32'(rvalid), 32'h0);
            next();
        end

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
